// File: rtl/id_stream_sched_pkg.sv
// ---------------------------------------------------------------------------
// id_stream_sched_pkg : shared encodings and char-class helpers.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
package id_stream_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } sched_state_e;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } core_state_e;

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= 8'h61) && (c <= 8'h7A)) || ((c >= 8'h41) && (c <= 8'h5A));
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_stream_sched_if.sv
// ---------------------------------------------------------------------------
// id_stream_sched_if : request/result bundle between sources and scheduler.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
interface id_stream_sched_if #(
  parameter int NREQ  = 2,
  parameter int SRC_W = 1,
  parameter int CNT_W = 8
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_char;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic [SRC_W-1:0]  res_src;
  logic [CNT_W-1:0]  res_count;
  logic              res_hit;
  logic              busy;

  modport master (
    output req_valid, req_char, req_last,
    input  req_ready, res_valid, res_src, res_count, res_hit, busy
  );

  modport slave (
    input  req_valid, req_char, req_last,
    output req_ready, res_valid, res_src, res_count, res_hit, busy
  );
endinterface
`default_nettype wire

// File: rtl/id_match_core.sv
// ---------------------------------------------------------------------------
// id_match_core : letters-then-digits recognizer with enable and sync clear.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
module id_match_core
  import id_stream_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] ch,
  output logic       out
);

  core_state_e state_q, state_d;
  logic        out_q, out_d;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    if (clr) begin
      state_d = S0;
      out_d   = 1'b0;
    end else if (en) begin
      if (is_letter(ch)) begin
        state_d = S1;
        out_d   = 1'b0;
      end else if (is_digit(ch) && (state_q != S0)) begin
        state_d = S2;
        out_d   = 1'b1;
      end else begin
        state_d = S0;
        out_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign out = out_q;

endmodule
`default_nettype wire

// File: rtl/id_stream_sched.sv
// ---------------------------------------------------------------------------
// id_stream_sched : round-robin sharing of one id_match_core across NREQ streams.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
module id_stream_sched
  import id_stream_sched_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int SRC_W = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  id_stream_sched_if.slave bus
);

  localparam logic [SRC_W:0]   c_nreq     = (SRC_W+1)'(NREQ);
  localparam logic [SRC_W-1:0] c_last_src = SRC_W'(NREQ - 1);
  localparam logic [CNT_W-1:0] c_cnt_max  = '1;

  sched_state_e     state_q, state_d;
  logic [SRC_W-1:0] rr_q, rr_d, grant_q, grant_d, pick;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prev_q, prev_d;
  logic [SRC_W:0]   idx;
  logic             pick_ok, g_valid, g_last, accept, core_clr, core_out, match_ev;
  logic [7:0]       g_char;

  // First valid source at or after the pointer, wrapping.
  always_comb begin
    pick    = rr_q;
    pick_ok = 1'b0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_q} + (SRC_W+1)'(k);
      if (idx >= c_nreq) idx = idx - c_nreq;
      if (!pick_ok && bus.req_valid[idx[SRC_W-1:0]]) begin
        pick_ok = 1'b1;
        pick    = idx[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    g_valid       = 1'b0;
    g_last        = 1'b0;
    g_char        = 8'h00;
    bus.req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == SRC_W'(i)) begin
        g_valid          = bus.req_valid[i];
        g_last           = bus.req_last[i];
        g_char           = bus.req_char[8*i +: 8];
        bus.req_ready[i] = (state_q == STREAM);
      end
    end
  end

  assign accept   = (state_q == STREAM) && g_valid;
  assign core_clr = (state_q == IDLE) && pick_ok;
  // Core output only moves on an accepted char, so a rise is exactly one match event.
  assign match_ev = core_out && !prev_q;

  id_match_core u_core (
    .clk   (clk),
    .reset (reset),
    .en    (accept),
    .clr   (core_clr),
    .ch    (g_char),
    .out   (core_out)
  );

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    prev_d  = core_clr ? 1'b0 : core_out;
    if (((state_q == STREAM) || (state_q == DRAIN)) && match_ev && (cnt_q != c_cnt_max))
      cnt_d = cnt_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (pick_ok) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM:  if (accept && g_last) state_d = DRAIN;
      DRAIN:   state_d = REPORT;
      REPORT: begin
        rr_d    = (grant_q == c_last_src) ? '0 : grant_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
    end
  end

  assign bus.res_valid = (state_q == REPORT);
  assign bus.res_src   = bus.res_valid ? grant_q : '0;
  assign bus.res_count = bus.res_valid ? cnt_q : '0;
  assign bus.res_hit   = bus.res_valid && (cnt_q != '0);
  assign bus.busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_id_stream_sched.sv
// ---------------------------------------------------------------------------
// tb_id_stream_sched : vector table, random streams vs. string-level model.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
module tb_id_stream_sched;

  localparam int NREQ   = 2;
  localparam int SRC_W  = 1;
  localparam int CNT_W  = 8;
  localparam int CNT_W2 = 2;

  typedef logic [7:0] bytq_t [$];
  typedef struct { logic [7:0] c; logic last; } chr_t;
  typedef struct { int src; string s; int gap; int cnt; int hit; } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_stream_sched_if #(.NREQ(NREQ), .SRC_W(SRC_W), .CNT_W(CNT_W))  bus ();
  id_stream_sched_if #(.NREQ(NREQ), .SRC_W(SRC_W), .CNT_W(CNT_W2)) bus2 ();

  id_stream_sched #(.NREQ(NREQ), .SRC_W(SRC_W), .CNT_W(CNT_W))  dut  (.clk(clk), .reset(rst), .bus(bus));
  id_stream_sched #(.NREQ(NREQ), .SRC_W(SRC_W), .CNT_W(CNT_W2)) dut2 (.clk(clk), .reset(rst), .bus(bus2));

  int compared = 0;
  int mismatched = 0;

  chr_t chq [NREQ][$];
  int   expq [NREQ][$];
  int   log_src [$];
  int   log_cnt [$];
  int   gap_cfg [NREQ];
  int   gap_cnt [NREQ];
  bit   pres [NREQ];
  chr_t cur [NREQ];
  bit   eng_on = 1'b0;
  bit   m_active = 1'b0;
  int   rr_m = 0;
  int   pred = 0;
  int   exp_c;
  logic [NREQ-1:0]   eng_mask;
  logic [NREQ-1:0]   man_valid = '0;
  logic [8*NREQ-1:0] man_char = '0;
  logic [NREQ-1:0]   man_last = '0;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_l(input logic [7:0] c);
    return (c >= "a" && c <= "z") || (c >= "A" && c <= "Z");
  endfunction

  function automatic bit is_d(input logic [7:0] c);
    return c >= "0" && c <= "9";
  endfunction

  // An identifier match happens wherever a digit directly follows a letter.
  function automatic int model_count(input bytq_t b, input int w);
    int n = 0;
    for (int i = 1; i < b.size(); i++)
      if (is_d(b[i]) && is_l(b[i-1])) n++;
    return (n > (1 << w) - 1) ? (1 << w) - 1 : n;
  endfunction

  function automatic bytq_t to_bytes(input string s);
    bytq_t b;
    for (int i = 0; i < s.len(); i++) b.push_back(s[i]);
    return b;
  endfunction

  function automatic int rr_pick(input int rr, input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      int j = (rr + k) % NREQ;
      if (v[j]) return j;
    end
    return rr;
  endfunction

  task automatic send_bytes(input int src, input bytq_t b);
    for (int i = 0; i < b.size(); i++) chq[src].push_back('{c: b[i], last: (i == b.size() - 1)});
    expq[src].push_back(model_count(b, CNT_W));
  endtask

  task automatic send(input int src, input string s);
    send_bytes(src, to_bytes(s));
  endtask

  task automatic wait_results(input int n);
    for (int k = 0; k < 6000 && log_src.size() < n; k++) @(negedge clk);
    check("results_arrived", int'(log_src.size() >= n), 1);
  endtask

  // Source drivers and result monitor, all acting on the falling edge.
  initial begin : engine
    forever begin
      @(negedge clk);
      if (!eng_on) begin
        bus.req_valid = man_valid;
        bus.req_char  = man_char;
        bus.req_last  = man_last;
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          if (!pres[i]) begin
            if (gap_cnt[i] > 0) gap_cnt[i]--;
            else if (chq[i].size() > 0) begin
              cur[i]  = chq[i].pop_front();
              pres[i] = 1'b1;
            end
          end
          bus.req_valid[i]      = pres[i];
          bus.req_char[8*i +: 8] = cur[i].c;
          bus.req_last[i]       = pres[i] & cur[i].last;
        end
        if (!rst) begin
          if (m_active) begin
            eng_mask       = '0;
            eng_mask[pred] = 1'b1;
            check("busy_in_string", int'(bus.busy), 1);
            check("ready_only_grant", int'(bus.req_ready & ~eng_mask), 0);
          end else begin
            check("busy_idle", int'(bus.busy), 0);
            check("ready_idle", int'(bus.req_ready), 0);
          end
          if (bus.res_valid) begin
            check("res_in_string", int'(m_active), 1);
            log_src.push_back(int'(bus.res_src));
            log_cnt.push_back(int'(bus.res_count));
            if (m_active) begin
              if (expq[pred].size() > 0) exp_c = expq[pred].pop_front();
              else exp_c = -1;
              check("res_src", int'(bus.res_src), pred);
              check("res_count", int'(bus.res_count), exp_c);
              check("res_hit", int'(bus.res_hit), int'(exp_c != 0));
              rr_m     = (pred + 1) % NREQ;
              m_active = 1'b0;
            end
          end
          if (!m_active && !bus.busy && (bus.req_valid != '0)) begin
            pred     = rr_pick(rr_m, bus.req_valid);
            m_active = 1'b1;
          end
          for (int i = 0; i < NREQ; i++) begin
            if (pres[i] && bus.req_ready[i]) begin
              pres[i]    = 1'b0;
              gap_cnt[i] = (gap_cfg[i] < 0) ? int'($urandom_range(0, 3)) : gap_cfg[i];
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  vec_t        vecs [10];
  logic [7:0]  oth [8];
  bytq_t       b;
  logic [7:0]  c;
  int          n, len, idx5, acc6, r5c, r5h, r5s;
  bit          got5, acc5;
  int          exp_order [4];

  initial begin : main
    vecs[0] = '{0, "ab12",    0, 1, 1};
    vecs[1] = '{1, "a1b2c3",  0, 3, 1};
    vecs[2] = '{1, "12ab",    0, 0, 0};
    vecs[3] = '{0, "x9",      3, 1, 1};
    vecs[4] = '{1, "Z",       0, 0, 0};
    vecs[5] = '{0, "a12b3",   1, 2, 1};
    vecs[6] = '{1, "ab_1",    0, 0, 0};
    vecs[7] = '{0, "\3411",   0, 0, 0};
    vecs[8] = '{1, "Q@9z`0",  2, 0, 0};
    vecs[9] = '{0, "Zz9",     0, 1, 1};
    oth = '{8'h20, 8'h5F, 8'h2F, 8'h3A, 8'h40, 8'h5B, 8'h60, 8'h7B};
    exp_order = '{0, 1, 0, 1};
    gap_cfg = '{0, 0};
    gap_cnt = '{0, 0};
    pres    = '{0, 0};
    bus2.req_valid = '0;
    bus2.req_char  = '0;
    bus2.req_last  = '0;

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_res_valid", int'(bus.res_valid), 0);
    check("rst_ready", int'(bus.req_ready), 0);
    check("rst_res_count", int'(bus.res_count), 0);
    check("rst_res_hit", int'(bus.res_hit), 0);
    check("rst_res_src", int'(bus.res_src), 0);

    // Both sources contending from the first cycle after reset.
    @(posedge clk); #1;
    rst = 1'b0;
    eng_on = 1'b1;
    send(0, "a1"); send(1, "b2"); send(0, "c3"); send(1, "d4");
    wait_results(4);
    for (int i = 0; i < 4; i++)
      if (log_src.size() > i) check("grant_order", log_src[i], exp_order[i]);

    foreach (vecs[v]) begin
      gap_cfg[vecs[v].src] = vecs[v].gap;
      n = log_src.size();
      send(vecs[v].src, vecs[v].s);
      wait_results(n + 1);
      if (log_src.size() > n) begin
        check("vec_src", log_src[n], vecs[v].src);
        check("vec_count", log_cnt[n], vecs[v].cnt);
        check("vec_hit", int'(log_cnt[n] != 0), vecs[v].hit);
      end
    end

    gap_cfg = '{-1, -1};
    n = log_src.size();
    for (int s = 0; s < 30; s++) begin
      b = {};
      len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++) begin
        case ($urandom_range(0, 5))
          0:       c = 8'(32'h61 + $urandom_range(0, 25));
          1:       c = 8'(32'h41 + $urandom_range(0, 25));
          2, 3:    c = 8'(32'h30 + $urandom_range(0, 9));
          4:       c = oth[$urandom_range(0, 7)];
          default: c = 8'(32'h80 + $urandom_range(0, 127));
        endcase
        b.push_back(c);
      end
      send_bytes($urandom_range(0, 1), b);
    end
    wait_results(n + 30);

    // Saturation on the narrow-counter instance.
    b = to_bytes("a1a1a1a1a1");
    idx5 = 0; got5 = 1'b0; r5c = -1; r5h = -1; r5s = -1;
    @(posedge clk); #1;
    bus2.req_valid = 2'b01;
    bus2.req_char  = {8'h00, b[0]};
    bus2.req_last  = 2'b00;
    for (int k = 0; k < 200 && !got5; k++) begin
      @(negedge clk); #1;
      acc5 = bus2.req_valid[0] && bus2.req_ready[0];
      if (bus2.res_valid) begin
        got5 = 1'b1;
        r5c  = int'(bus2.res_count);
        r5h  = int'(bus2.res_hit);
        r5s  = int'(bus2.res_src);
      end
      @(posedge clk); #1;
      if (acc5) begin
        idx5++;
        if (idx5 >= b.size()) bus2.req_valid = '0;
        else begin
          bus2.req_char[7:0] = b[idx5];
          bus2.req_last[0]   = (idx5 == b.size() - 1);
        end
      end
    end
    check("sat_done", int'(got5), 1);
    check("sat_count_model", r5c, model_count(b, CNT_W2));
    check("sat_count", r5c, 3);
    check("sat_hit", r5h, 1);
    check("sat_src", r5s, 0);

    // Leave the pointer at 1, then abort a string with reset.
    gap_cfg = '{0, 0};
    n = log_src.size();
    send(0, "k");
    wait_results(n + 1);
    @(posedge clk); #1;
    eng_on    = 1'b0;
    man_valid = 2'b01;
    man_char  = {8'h00, "a"};
    man_last  = 2'b00;
    acc6 = 0;
    for (int k = 0; k < 20 && acc6 < 2; k++) begin
      @(negedge clk); #1;
      if (bus.req_valid[0] && bus.req_ready[0]) acc6++;
      @(posedge clk); #1;
      if (acc6 == 1) man_char[7:0] = "b";
      else if (acc6 == 2) man_valid = '0;
    end
    check("abort_accepts", acc6, 2);
    rst = 1'b1;
    #1;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_ready", int'(bus.req_ready), 0);
    check("abort_res_valid", int'(bus.res_valid), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      check("abort_no_res", int'(bus.res_valid), 0);
      check("abort_idle", int'(bus.busy), 0);
    end
    for (int i = 0; i < NREQ; i++) begin
      chq[i].delete();
      expq[i].delete();
      pres[i]    = 1'b0;
      gap_cnt[i] = 0;
    end
    rr_m     = 0;
    m_active = 1'b0;
    eng_on   = 1'b1;
    send(0, "b2");
    send(1, "c3");
    wait_results(n + 3);
    if (log_src.size() >= n + 3) begin
      check("resend_src", log_src[n+1], 0);
      check("resend_count", log_cnt[n+1], 1);
      check("resend_next_src", log_src[n+2], 1);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
